mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 3-bit output channel among four requesters, each presenting a 3-bit data word. It sits in front of the 4:1 data selector path. It decides which requester owns the channel, drives the 2-bit select and one-hot grant, and registers the selected word onto `f` with a `valid` qualifier. Grants are bounded by a hold limit so no requester can starve the others.

## Interface
Parameters:
- `HOLD_MAX`, default 4: maximum consecutive cycles one requester may hold the grant. Legal range 1..15.

Ports:
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst`  in  1  : synchronous, active-high reset, sampled on `clk` rising edge.
- `req`  in  4  : request lines; `req[i]` belongs to requester i.
- `w0`, `w1`, `w2`, `w3`  in  3 each  : data words of requesters 0..3.
- `f`  out  3  : registered output word of the granted requester.
- `valid`  out  1  : `f` holds a word transferred this cycle.
- `gnt`  out  4  : one-hot grant, registered; all zero when idle.
- `sel`  out  2  : binary index of the current/last grantee, registered.
- `busy`  out  1  : high in GRANT state, equal to `|gnt`.

## Operation
Internal state:
- FSM with two states, IDLE and GRANT.
- `ptr` (2 bits): index of the last grantee. Reset value 3, so requester 0 has first priority.
- `cnt`: hold counter, width sufficient for `HOLD_MAX`.

Round-robin pick: scan indices `ptr+1`, `ptr+2`, `ptr+3`, `ptr+4` (mod 4) in that order. The first index with `req` high wins. The same rule applies at every arbitration point.

Reset (`rst`=1 at an edge, overriding everything, including mid-grant):
- state goes to IDLE.
- `gnt`=0, `sel`=0, `f`=3'b000, `valid`=0, `busy`=0.
- `cnt`=0, `ptr`=3.

IDLE, at each edge:
- If `req`=0: remain in IDLE with `valid`=0; `f` and `sel` hold.
- Otherwise: pick winner k. Then `gnt`<=onehot(k), `sel`<=k, `f`<=w_k, `valid`<=1, `cnt`<=1, `ptr`<=k, and go to GRANT.

GRANT with grantee s, at each edge:
- Continue if `req[s]`=1 and `cnt`<`HOLD_MAX`: `f`<=w_s, `valid`<=1, `cnt`<=`cnt`+1.
- Otherwise (`req[s]` dropped, or `cnt`==`HOLD_MAX`), re-arbitrate in the same edge with no idle bubble:
  - If any `req` is high: pick winner k from `ptr`=s, then load `gnt`, `sel`, `f`, `valid`, `cnt`=1 and `ptr` as in IDLE. k may equal s only when s is the sole requester at a hold expiry; its count then restarts at 1.
  - If no `req` is high: go to IDLE with `gnt`=0, `valid`=0; `f` and `sel` hold their last values.
- Requests from non-grantees arriving mid-grant are ignored until the next arbitration point.

Invariants:
- `gnt` is always zero or one-hot.
- `gnt[sel]`==1 whenever `busy`.
- `valid`=1 implies `busy`=1.

## Timing
- Latency is one cycle from the sampling edge: the `req`/`w` values seen at edge n appear on `gnt`/`sel`/`f`/`valid` after edge n.
- A requester keeping `req` high is serviced for at most `HOLD_MAX` consecutive cycles. With `HOLD_MAX`=1, every edge re-arbitrates.
- The worst-case wait for a continuously requesting input is 3×`HOLD_MAX` cycles.
- A grantee dropping `req` at edge n loses the grant at edge n. Its data from that edge is not transferred.
- If `rst` and `req` are both high at an edge, reset wins. Arbitration starts at the next edge.
- Every output is registered; no combinational path runs from inputs to outputs.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `f`=000, `valid`=0, `busy`=0, `sel`=0. After releasing `rst`, the first edge grants requester 0 (`gnt`=0001).
- **Single requester:** `req`=0100, `w2`=3'b101 for 3 cycles, `HOLD_MAX`=4 → `gnt`=0100, `sel`=2, `f`=101, `valid`=1 for 3 cycles. `req` drops → IDLE next edge, `f` holds 101.
- **Fairness under saturation:** `req`=1111, `HOLD_MAX`=2 → grant order 0,0,1,1,2,2,3,3,0,…. No bubble between grantees, and `valid` stays high.
- **Hold expiry, sole requester:** `req`=0010 for 10 cycles, `HOLD_MAX`=4 → `gnt` stays 0010 and `valid` continuous. `cnt` restarts after every 4 cycles.
- **Early release:** grantee 1 drops `req` after 1 cycle while `req[3]` and `req[0]` are high → next grant goes to 3 (not 0), with `f`=w3 at that edge.
- **Reset mid-grant:** assert `rst` during the second grant cycle of requester 2 → all outputs return to reset values at that edge. With `req`=1111 afterward, the next grant goes to requester 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 3-bit output channel among four requesters.
// Grant tenure is capped at HOLD_MAX cycles; all outputs are registered.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [2:0] w0,
  input  logic [2:0] w1,
  input  logic [2:0] w2,
  input  logic [2:0] w3,
  output logic [2:0] f,
  output logic       valid,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    f_q, f_d;
  logic          valid_q, valid_d;

  logic       pickFound;
  logic [1:0] pickIdx;
  logic [1:0] cand;
  logic       keepGrant;

  function automatic logic [2:0] wordOf(input logic [1:0] idx, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c,
                                        input logic [2:0] d);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  // Scan ptr+1 .. ptr+4 so the last grantee has the lowest priority.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pickFound && req[cand]) begin
        pickFound = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    f_d       = f_q;
    valid_d   = 1'b0;
    keepGrant = (state_q == GRANT) && req[sel_q] && (cnt_q < CW'(HOLD_MAX));

    if (keepGrant) begin
      f_d     = wordOf(sel_q, w0, w1, w2, w3);
      valid_d = 1'b1;
      cnt_d   = cnt_q + CW'(1);
    end else if (pickFound) begin
      // Arbitration point: from IDLE, on release, or on hold expiry.
      state_d = GRANT;
      gnt_d   = 4'b0001 << pickIdx;
      sel_d   = pickIdx;
      f_d     = wordOf(pickIdx, w0, w1, w2, w3);
      valid_d = 1'b1;
      cnt_d   = CW'(1);
      ptr_d   = pickIdx;
    end else begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      f_q     <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      f_q     <= f_d;
      valid_q <= valid_d;
    end
  end

  assign f     = f_q;
  assign valid = valid_q;
  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign busy  = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (HOLD_MAX 4 and 2) driven in lockstep,
// checked against a reference model scoreboard plus directed expectations.
module tb_mux_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [2:0] f;
    logic       valid;
    logic       busy;
  } outT;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [2:0] w0, w1, w2, w3;

  logic [2:0] f4, f2;
  logic       valid4, valid2, busy4, busy2;
  logic [3:0] gnt4, gnt2;
  logic [1:0] sel4, sel2;

  int testCount = 0;
  int failCount = 0;

  outT q4[$];
  outT q2[$];

  // Reference model state, index 0 -> HOLD_MAX 4, index 1 -> HOLD_MAX 2.
  int mState[2];
  int mPtr[2];
  int mCnt[2];
  int mGnt[2];
  int mSel[2];
  int mF[2];
  int mValid[2];
  int mHold[2] = '{4, 2};

  mux_rr_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .f(f4), .valid(valid4), .gnt(gnt4), .sel(sel4), .busy(busy4)
  );

  mux_rr_arbiter #(.HOLD_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .req(req),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .f(f2), .valid(valid2), .gnt(gnt2), .sel(sel2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wordAt(input int idx);
    case (idx)
      0:       return int'(w0);
      1:       return int'(w1);
      2:       return int'(w2);
      default: return int'(w3);
    endcase
  endfunction

  task automatic modelStep(input int n);
    outT e;
    int winner;
    if (rst) begin
      mState[n] = 0; mPtr[n] = 3; mCnt[n] = 0;
      mGnt[n] = 0; mSel[n] = 0; mF[n] = 0; mValid[n] = 0;
    end else if (mState[n] == 1 && req[mSel[n]] && mCnt[n] < mHold[n]) begin
      mF[n] = wordAt(mSel[n]); mValid[n] = 1; mCnt[n] = mCnt[n] + 1;
    end else begin
      winner = -1;
      for (int k = 1; k <= 4; k++)
        if (winner < 0 && req[(mPtr[n] + k) % 4]) winner = (mPtr[n] + k) % 4;
      if (winner >= 0) begin
        mState[n] = 1; mGnt[n] = 1 << winner; mSel[n] = winner;
        mF[n] = wordAt(winner); mValid[n] = 1; mCnt[n] = 1; mPtr[n] = winner;
      end else begin
        mState[n] = 0; mGnt[n] = 0; mValid[n] = 0;
      end
    end
    e.gnt = 4'(mGnt[n]); e.sel = 2'(mSel[n]); e.f = 3'(mF[n]);
    e.valid = 1'(mValid[n]); e.busy = (mState[n] == 1);
    if (n == 0) q4.push_back(e); else q2.push_back(e);
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    outT e, o;
    if (q4.size() == 0 || q2.size() == 0) begin
      testCount++;
      failCount++;
      $error("FAIL scoreboard_empty: observed %0d/%0d entries expected at least 1", q4.size(), q2.size());
      return;
    end
    e = q4.pop_front();
    o = '{gnt4, sel4, f4, valid4, busy4};
    testCount++;
    assert (o === e) else begin
      failCount++;
      $error("FAIL sb_hold4 @%0t: observed %b expected %b", $time, o, e);
    end
    e = q2.pop_front();
    o = '{gnt2, sel2, f2, valid2, busy2};
    testCount++;
    assert (o === e) else begin
      failCount++;
      $error("FAIL sb_hold2 @%0t: observed %b expected %b", $time, o, e);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    req = rq;
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int order[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    rst = 1'b1; req = 4'b0000;
    w0 = 3'd1; w1 = 3'd2; w2 = 3'd3; w3 = 3'd4;

    // Reset with all requests high.
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b1111);
    checkVal("rst_gnt", 8'(gnt4), 8'h0);
    checkVal("rst_f", 8'(f4), 8'h0);
    checkVal("rst_valid", 8'(valid4), 8'h0);
    checkVal("rst_busy", 8'(busy4), 8'h0);
    checkVal("rst_sel", 8'(sel4), 8'h0);
    applyStimulus(1'b0, 4'b1111);
    checkVal("first_gnt4", 8'(gnt4), 8'h1);
    checkVal("first_gnt2", 8'(gnt2), 8'h1);
    applyStimulus(1'b0, 4'b0000);

    // Single requester 2.
    w2 = 3'b101;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0100);
      checkVal("single_gnt", 8'(gnt4), 8'h4);
      checkVal("single_f", 8'(f4), 8'h5);
      checkVal("single_sel", 8'(sel4), 8'h2);
    end
    w2 = 3'b010;
    applyStimulus(1'b0, 4'b0000);
    checkVal("release_valid", 8'(valid4), 8'h0);
    checkVal("release_gnt", 8'(gnt4), 8'h0);
    checkVal("release_f_hold", 8'(f4), 8'h5);
    checkVal("release_sel_hold", 8'(sel4), 8'h2);

    // Saturation after reset: HOLD_MAX 2 alternates pairs.
    applyStimulus(1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      w0 = 3'(i); w1 = 3'(i + 1); w2 = 3'(i + 2); w3 = 3'(i + 3);
      applyStimulus(1'b0, 4'b1111);
      checkVal("sat_gnt2", 8'(gnt2), 8'(1 << order[i]));
      checkVal("sat_valid2", 8'(valid2), 8'h1);
    end

    // Sole requester beyond the hold limit keeps the grant.
    for (int i = 0; i < 10; i++) begin
      w1 = 3'(7 - (i % 8));
      applyStimulus(1'b0, 4'b0010);
      checkVal("sole_gnt4", 8'(gnt4), 8'h2);
      checkVal("sole_f4", 8'(f4), 8'(7 - (i % 8)));
      checkVal("sole_valid2", 8'(valid2), 8'h1);
    end

    // Early release by grantee 1 hands over to 3 ahead of 0.
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0010);
    checkVal("early_gnt1", 8'(gnt4), 8'h2);
    w0 = 3'b011; w3 = 3'b110;
    applyStimulus(1'b0, 4'b1001);
    checkVal("early_gnt", 8'(gnt4), 8'h8);
    checkVal("early_f", 8'(f4), 8'h6);
    checkVal("early_sel", 8'(sel4), 8'h3);

    // Reset during the second grant cycle of requester 2.
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0100);
    checkVal("mid_pre_gnt", 8'(gnt4), 8'h4);
    applyStimulus(1'b1, 4'b0100);
    checkVal("mid_rst_gnt", 8'(gnt4), 8'h0);
    checkVal("mid_rst_valid", 8'(valid4), 8'h0);
    checkVal("mid_rst_f", 8'(f4), 8'h0);
    applyStimulus(1'b0, 4'b1111);
    checkVal("mid_after_gnt", 8'(gnt4), 8'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
